// File: rtl/snn_pkg.sv
// Shared constants, FSM state encoding and index-width helper for the SNN readout blocks.
package snn_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned WIN_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear; count advances only while enabled.
module sat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] peek_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Value including this cycle's increment, saturating at all-ones.
  always_comb begin
    peek_c = count;
    if (enable && inc && (count != CNT_MAX)) begin
      peek_c = count + CNT_W'(1);
    end
  end

  // Counter register; clear wins over increment and only acts when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= clr ? '0 : peek_c;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Per-channel spike counting over a programmable window, streamed out one channel per beat.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WIN_W  = WIN_W_DEF,
  localparam int unsigned CH_W  = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WIN_W-1:0]  window_len,
  input  logic [NUM_CH-1:0] spk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  output logic              overrun
);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIN_W-1:0] timer;
  logic [WIN_W-1:0] win_last_c;
  logic             win_end_c;

  logic [NUM_CH-1:0][CNT_W-1:0] live;
  logic [NUM_CH-1:0][CNT_W-1:0] live_peek;
  logic [NUM_CH-1:0][CNT_W-1:0] snap;
  logic [NUM_CH-1:0][CNT_W-1:0] snap_nxt;

  logic             hs_c;
  logic             done_c;
  logic             load_c;
  logic             ovr_set_c;

  logic [CH_W-1:0]  out_ch_nxt;
  logic [CNT_W-1:0] out_count_nxt;
  logic             out_valid_nxt;
  logic             out_last_nxt;
  logic             overrun_nxt;

  // A zero window length behaves as a one-cycle window.
  assign win_last_c = (window_len == '0) ? '0 : (window_len - WIN_W'(1));
  assign win_end_c  = enable && (timer == win_last_c);

  // Window timer: wraps at window end, otherwise free-runs (including past 2^WIN_W).
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (enable) begin
      timer <= win_end_c ? '0 : (timer + WIN_W'(1));
    end
  end

  // One saturating live counter per spike channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .inc    (spk[i]),
      .clr    (win_end_c),
      .count  (live[i]),
      .peek_c (live_peek[i])
    );
  end

  // Beat acceptance and completion of the final beat.
  assign hs_c   = (state == SEND) && out_ready;
  assign done_c = hs_c && out_last;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a window end during an unfinished transfer is dropped as an overrun.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    ovr_set_c = 1'b0;
    case (state)
      IDLE: begin
        if (win_end_c) begin
          state_nxt = SEND;
          load_c    = 1'b1;
        end
      end
      SEND: begin
        if (done_c) begin
          if (win_end_c) begin
            load_c = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (win_end_c) begin
          ovr_set_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output next-values: channel pointer, snapshot capture and beat payload.
  always_comb begin
    out_ch_nxt = out_ch;
    if (load_c) begin
      out_ch_nxt = '0;
    end else if (hs_c) begin
      out_ch_nxt = out_last ? '0 : (out_ch + CH_W'(1));
    end
    snap_nxt      = load_c ? live_peek : snap;
    out_valid_nxt = (state_nxt == SEND);
    out_last_nxt  = out_valid_nxt && (out_ch_nxt == CH_LAST);
    out_count_nxt = out_valid_nxt ? snap_nxt[out_ch_nxt] : '0;
    overrun_nxt   = overrun | ovr_set_c;
  end

  // Snapshot and registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      snap      <= snap_nxt;
      out_valid <= out_valid_nxt;
      out_ch    <= out_ch_nxt;
      out_count <= out_count_nxt;
      out_last  <= out_last_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receive-side counterpart to the LIF spike generators: turns per-channel spike trains back into spike counts over a programmable observation window.
- Sits downstream of the LIF layers. Each window's counts are sent out one channel per beat on a valid/ready stream, for readout pins or a host-side consumer.

Parameters:
- NUM_CH, 4, number of spike input channels (≥1).
- CNT_W, 4, width of each per-channel count (saturating).
- WIN_W, 8, width of the window-length field.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  window timer and spike counting run only while high.
- window_len  input  WIN_W  window length in cycles; 0 is treated as 1.
- spk  input  NUM_CH  spike inputs, one per channel, one cycle per spike (level sampled each cycle).
- out_valid  output  1  count beat available.
- out_ready  input  1  consumer accepts beat when high together with out_valid.
- out_ch  output  clog2(NUM_CH) (min 1)  channel index of current beat.
- out_count  output  CNT_W  spike count of out_ch for the completed window.
- out_last  output  1  high on the beat with out_ch == NUM_CH-1.
- overrun  output  1  sticky: a window ended while the previous snapshot was still being sent.

Behaviour:
- Reset (sync, active-high): window timer=0, live counters=0, snapshot regs=0, FSM=IDLE, out_valid=0, out_ch=0, out_count=0, out_last=0, overrun=0. Reset mid-transfer aborts the transfer; no partial beats follow.
- Window timer:
  - Increments each enabled cycle.
  - Window end is the enabled cycle where timer == max(window_len,1)-1. On that cycle the timer wraps to 0.
  - enable low freezes the timer and counters; nothing is cleared.
  - window_len is sampled every cycle. If it is lowered below the current timer value, the timer keeps counting and wraps at 2^WIN_W, then continues normally.
- Live counters:
  - Per channel, +1 on each enabled cycle with spk[i]=1.
  - Saturate at 2^CNT_W-1; never wrap.
  - A spike on the window-end cycle counts into the closing window.
  - Live counters clear to 0 at the window-end edge, then accumulate the new window from the next cycle.
- Snapshot: at the window-end edge, if FSM is IDLE, the final live values (including the end-cycle spike) are copied into snapshot regs and FSM goes to SEND.
- FSM states:
  - IDLE: out_valid=0.
  - SEND: out_valid=1, out_count=snapshot[out_ch], out_last=(out_ch==NUM_CH-1).
    - On out_valid&&out_ready: if out_last, go to IDLE with out_ch=0; otherwise out_ch+1.
    - While out_ready is low, out_ch and out_count hold stable.
- Latency: window end at cycle N gives out_valid=1 with out_ch=0 at cycle N+1. Minimum transfer is NUM_CH cycles with out_ready held high.
- Overrun:
  - A window end while FSM is SEND drops that window's snapshot: current snapshot regs are kept, live counters still clear, and overrun is set.
  - A window end on the same cycle as the final handshake (out_last accepted) is not an overrun. The new snapshot loads and FSM stays in SEND with out_ch=0.
  - overrun clears only on reset.

Decomposition:
- Shared package snn_pkg: the default CNT_W/WIN_W constants, an FSM state enum (IDLE, SEND), and a channel-index width function clog2_min1.
- One natural sub-module: sat_counter (CNT_W wide, inc/clr/enable, saturating). It is instantiated NUM_CH times.
- Timer, snapshot, and FSM live in the top.

Test Plan:
- window_len=8, enable=1, spk=4'b0001 every cycle, out_ready=1 → beats (ch0,8),(ch1,0),(ch2,0),(ch3,0). out_valid first high cycle 8 after reset release; out_last on ch3.
- window_len=20, spk[2] every cycle → ch2 count saturates at 15, no wrap; other channels 0.
- window_len=10, spikes on ch1 at window cycles 0 and 9 → closing window reports ch1=2. A spike at cycle 10 appears in the next window (1).
- window_len=2, out_ready=0 for 10 cycles → overrun=1 and stays high. First snapshot is still delivered intact once out_ready=1.
- window_len=4, NUM_CH=4, out_ready=1 → final handshake coincides with the next window end; overrun stays 0 and the new transfer starts at ch0 the next cycle.
- Assert reset during SEND at ch2 → next cycle out_valid=0, overrun=0, counters 0. The first post-reset window reports only post-reset spikes.
